// File: rtl/i2s_audio_tx.sv
// I2S transmitter: sample FIFO, bit-clock divider and MSB-first serializer.
// Each popped mono sample is sent on both left and right slots.
module i2s_audio_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int BCLK_DIV   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [DATA_WIDTH-1:0]         audio_in,
  input  logic                          audio_valid,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underrun
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = PW + 1;
  localparam int CW  = $clog2(BCLK_DIV);
  localparam int BW  = $clog2(2 * DATA_WIDTH);

  localparam logic [CW-1:0] DIV_MAX = CW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(2 * DATA_WIDTH - 1);
  localparam logic [BW-1:0] BIT_R   = BW'(DATA_WIDTH);
  localparam logic [BW-1:0] WS_LO   = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] WS_HI   = BW'(2 * DATA_WIDTH - 2);
  localparam logic [LW-1:0] FULL    = LW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic                  und_q, und_d;
  logic [CW-1:0]         div_q, div_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  bclk_q, bclk_d;
  logic                  ws_q, ws_d;
  logic [DATA_WIDTH-1:0] frame_q, frame_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;

  logic empty;
  logic full;
  logic fall;
  logic frame_start;
  logic push;
  logic pop;

  always_comb begin
    empty       = (level_q == '0);
    full        = (level_q == FULL);
    fall        = enable && bclk_q && (div_q == DIV_MAX);
    frame_start = fall && (bit_q == BIT_MAX);
    pop         = frame_start && !empty;
    // a pop frees the slot the same cycle, so a full FIFO can still accept
    push        = audio_valid && (!full || pop);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (audio_valid && !push) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    div_d   = div_q;
    bit_d   = bit_q;
    bclk_d  = bclk_q;
    ws_d    = ws_q;
    frame_d = frame_q;
    shift_d = shift_q;
    und_d   = frame_start && empty;
    if (!enable) begin
      div_d   = '0;
      bit_d   = BIT_MAX;
      bclk_d  = 1'b0;
      ws_d    = 1'b0;
      shift_d = '0;
    end else begin
      div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
      if (div_q == DIV_MAX) begin
        bclk_d = !bclk_q;
      end
      if (fall) begin
        bit_d = (bit_q == BIT_MAX) ? '0 : bit_q + 1'b1;
        // word select leads the slot MSB by one bit
        ws_d  = (bit_d >= WS_LO) && (bit_d <= WS_HI);
        if (frame_start) begin
          frame_d = pop ? mem_q[rd_ptr_q] : '0;
          shift_d = frame_d;
        end else if (bit_d == BIT_R) begin
          shift_d = frame_q;
        end else begin
          shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= audio_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      und_q    <= 1'b0;
      div_q    <= '0;
      bit_q    <= BIT_MAX;
      bclk_q   <= 1'b0;
      ws_q     <= 1'b0;
      frame_q  <= '0;
      shift_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      und_q    <= und_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      bclk_q   <= bclk_d;
      ws_q     <= ws_d;
      frame_q  <= frame_d;
      shift_q  <= shift_d;
    end
  end

  assign i2s_bclk   = bclk_q;
  assign i2s_lrclk  = ws_q;
  assign i2s_sdata  = shift_q[DATA_WIDTH-1];
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign underrun   = und_q;

endmodule

// File: doc/i2s_audio_tx.md
I2S_AUDIO_TX -- requirements
Module: i2s_audio_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sample width; the I2S slot width equals DATA_WIDTH.
REQ-002 Parameter FIFO_DEPTH, default 4, sample buffer depth, power of two, minimum 2.
REQ-003 Parameter BCLK_DIV, default 8, clk cycles per bclk half-period, minimum 2.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  serial output enable.
REQ-007 audio_in  input  DATA_WIDTH  signed sample from the filter stage's audio_out.
REQ-008 audio_valid  input  1  one-cycle strobe, driven from the filter stage's audio_ready.
REQ-009 i2s_bclk  output  1  bit clock.
REQ-010 i2s_lrclk  output  1  word select; 0 = left, 1 = right.
REQ-011 i2s_sdata  output  1  serial data, MSB first.
REQ-012 fifo_level  output  clog2(FIFO_DEPTH)+1  number of stored samples.
REQ-013 overflow  output  1  sticky flag for a dropped sample.
REQ-014 underrun  output  1  one-cycle pulse when a frame starts with the FIFO empty.

Function
REQ-015 The FIFO SHALL write audio_in when audio_valid=1 and the FIFO is not full; write pointer wraps modulo FIFO_DEPTH.
REQ-016 When audio_valid=1 and the FIFO is full with no pop that cycle, the sample SHALL be dropped and overflow set; overflow clears only on rst.
REQ-017 When a push and a pop occur in the same cycle with the FIFO full, both SHALL complete; no drop, no overflow, level unchanged.
REQ-018 The divider div_cnt SHALL count 0..BCLK_DIV-1 while enable=1; at BCLK_DIV-1 it wraps to 0 and i2s_bclk toggles.
REQ-019 On each bclk falling edge (the cycle bclk goes 1->0), bit_cnt SHALL advance modulo 2*DATA_WIDTH.
REQ-020 When bit_cnt wraps to 0 (frame start), one sample SHALL be popped into the frame register.
REQ-021 If the FIFO is empty at frame start, the frame register SHALL be loaded with 0 (mute) and underrun pulsed for exactly that cycle.
REQ-022 A push in the same cycle as an empty-FIFO frame start SHALL be stored, not used for that frame; underrun still pulses.
REQ-023 The shift register SHALL load the frame register at bit_cnt=0 (left slot) and again at bit_cnt=DATA_WIDTH (right slot); mono sample on both channels.
REQ-024 At every other bclk falling edge it SHALL shift left by one; i2s_sdata = shift register MSB, so data changes only on bclk falling edges.
REQ-025 i2s_lrclk SHALL be 1 for bit_cnt in DATA_WIDTH-1..2*DATA_WIDTH-2 and 0 otherwise (standard I2S: word select leads MSB by one bit).
REQ-026 i2s_lrclk SHALL change on the same clk edge as the bclk falling edge.
REQ-027 While enable=0: i2s_bclk, i2s_lrclk and i2s_sdata SHALL be 0; div_cnt=0 and bit_cnt=2*DATA_WIDTH-1; the FIFO still accepts writes; no pops.
REQ-028 Deasserting enable mid-frame SHALL abort the frame on the next clk with no pop; the partial sample is discarded.
REQ-029 Samples SHALL leave in arrival order, bit-exact, with no arithmetic applied.

Reset
REQ-030 On rst=1 at a clk edge: FIFO empty, fifo_level=0, overflow=0, underrun=0, i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, div_cnt=0, bit_cnt=2*DATA_WIDTH-1, frame and shift registers 0.
REQ-031 rst SHALL override enable and audio_valid in the same cycle; a reset mid-frame discards the frame and all FIFO contents.
REQ-032 After reset with enable=1, the first bclk rise SHALL occur BCLK_DIV cycles later and the first frame start BCLK_DIV cycles after that.

Verification
REQ-033 Defaults; push 16'hA5C3 then enable -> left and right slots each shift out 1010010111000011 MSB first; lrclk rises one bclk before the right MSB.
REQ-034 Enable with empty FIFO -> underrun pulses once per frame (every 2*16*2*8 = 512 clks); sdata stays 0.
REQ-035 Enable=0; push 5 samples -> fifo_level=4, overflow=1; the 5th sample is never transmitted.
REQ-036 FIFO full; push on the exact frame-start cycle -> no overflow, fifo_level stays 4.
REQ-037 Assert rst mid-right-slot -> all outputs 0 next cycle; the first frame start comes 16 clks after rst falls.
REQ-038 Push 16'h8000, 16'h7FFF, 16'h0001 -> transmitted in order, each on both channels, bit-exact.
